// File: rtl/ddc_phase_sched.sv
// ddc_phase_sched: round-robin DDS phase-word scheduler for the DDC.
// Per-channel {poff, pinc} words are written into shadow registers and
// copied into the active set in one cycle at a frame boundary. The
// first frame after a copy carries resync on every slot.

// Per-channel storage lane: shadow word plus active copy.
module ddc_phase_ch #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_i,
  input  logic         xfer_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] shd_o,
  output logic [W-1:0] act_o
);
  logic [W-1:0] shd_q, act_q;

  // Shadow takes writes in any state; active copies the pre-edge shadow,
  // so a write landing on the transfer edge stays out of the active set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shd_q <= '0;
      act_q <= '0;
    end else begin
      if (wr_i)   shd_q <= wdata_i;
      if (xfer_i) act_q <= shd_q;
    end
  end

  assign shd_o = shd_q;
  assign act_o = act_q;
endmodule

module ddc_phase_sched #(
  parameter  int N_CH   = 8,
  parameter  int PINC_W = 32,
  parameter  int POFF_W = 32,
  localparam int CH_W   = $clog2(N_CH),
  localparam int PW     = PINC_W + POFF_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_wr,
  input  logic [7:0]        cfg_ch,
  input  logic [PINC_W-1:0] cfg_pinc,
  input  logic [POFF_W-1:0] cfg_poff,
  input  logic              cfg_commit,
  input  logic              tick_in,
  output logic [PW-1:0]     phase_out,
  output logic              phase_valid,
  output logic              resync_out,
  output logic [CH_W-1:0]   ch_out,
  output logic              frame_start,
  output logic              commit_pending,
  output logic              cfg_err
);
  typedef enum logic [1:0] {IDLE, PEND, RSYNC, RUN} state_e;

  localparam logic [7:0] N_CH8 = 8'(N_CH);

  state_e                     state_q;
  logic [CH_W-1:0]            slot_q;      // slot emitted by the next tick
  logic                       rlat_q;      // commit latched during RSYNC
  logic [PW-1:0]              phase_q;
  logic                       valid_q, resync_q, frame_q, cp_q, err_q;
  logic [CH_W-1:0]            ch_q;
  logic [N_CH-1:0][PW-1:0]    shd_w, act_w;

  logic wr_ok, emit, slot0, slot_last, xfer;

  assign wr_ok     = cfg_wr && (cfg_ch < N_CH8);
  assign emit      = tick_in && (state_q != IDLE);
  assign slot0     = (slot_q == '0);
  assign slot_last = &slot_q;              // N_CH is a power of two
  assign xfer      = (state_q == PEND) && tick_in && slot0;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [7:0] IDX = 8'(i);
    ddc_phase_ch #(.W(PW)) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .wr_i    (wr_ok && (cfg_ch == IDX)),
      .xfer_i  (xfer),
      .wdata_i ({cfg_poff, cfg_pinc}),
      .shd_o   (shd_w[i]),
      .act_o   (act_w[i])
    );
  end

  // Scheduler FSM: slot counter, commit handshake and registered slot outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      rlat_q   <= 1'b0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
      resync_q <= 1'b0;
      frame_q  <= 1'b0;
      ch_q     <= '0;
      cp_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= emit;
      if (cfg_wr && !wr_ok) err_q <= 1'b1;

      if (emit) begin
        slot_q   <= slot_q + CH_W'(1);
        ch_q     <= slot_q;
        // On the transfer edge the active set is being loaded, so slot 0
        // is taken straight from the shadow it is loaded from.
        phase_q  <= xfer ? shd_w[0] : act_w[slot_q];
        frame_q  <= slot0;
        resync_q <= (state_q == RSYNC) || xfer;
      end

      case (state_q)
        IDLE: if (cfg_commit) begin
          state_q <= PEND;
          cp_q    <= 1'b1;
        end
        PEND: if (xfer) begin
          state_q <= RSYNC;
          cp_q    <= 1'b0;
        end
        RSYNC: begin
          if (emit && slot_last) begin
            // A commit seen during the resync frame re-arms the transfer;
            // the counter wraps to 0 so it fires on the very next tick.
            if (rlat_q || cfg_commit) begin
              state_q <= PEND;
              cp_q    <= 1'b1;
            end else begin
              state_q <= RUN;
              cp_q    <= 1'b0;
            end
            rlat_q <= 1'b0;
          end else if (cfg_commit) begin
            rlat_q <= 1'b1;
            cp_q   <= 1'b1;
          end
        end
        RUN: if (cfg_commit) begin
          state_q <= PEND;
          cp_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phase_out      = phase_q;
  assign phase_valid    = valid_q;
  assign resync_out     = resync_q;
  assign ch_out         = ch_q;
  assign frame_start    = frame_q;
  assign commit_pending = cp_q;
  assign cfg_err        = err_q;
endmodule

// File: tb/tb_ddc_phase_sched.sv
// Bench for ddc_phase_sched: directed scenarios plus random traffic,
// all checked each cycle against a frame-level reference model.
module tb_ddc_phase_sched;
  localparam int N_CH = 8, PINC_W = 32, POFF_W = 32, CH_W = 3, PW = 64;

  logic clk = 1'b0, resetn = 1'b0;
  logic cfg_wr = 1'b0, cfg_commit = 1'b0, tick_in = 1'b0;
  logic [7:0] cfg_ch = '0;
  logic [PINC_W-1:0] cfg_pinc = '0;
  logic [POFF_W-1:0] cfg_poff = '0;
  logic [PW-1:0] phase_out;
  logic phase_valid, resync_out, frame_start, commit_pending, cfg_err;
  logic [CH_W-1:0] ch_out;

  ddc_phase_sched #(.N_CH(N_CH), .PINC_W(PINC_W), .POFF_W(POFF_W)) dut (
    .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_pinc(cfg_pinc), .cfg_poff(cfg_poff), .cfg_commit(cfg_commit),
    .tick_in(tick_in), .phase_out(phase_out), .phase_valid(phase_valid),
    .resync_out(resync_out), .ch_out(ch_out), .frame_start(frame_start),
    .commit_pending(commit_pending), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int vec = 0, errs = 0;

  // Reference model: shadow/active tables, pending commit flag, number of
  // resync slots still owed, and next slot to emit.
  logic [PW-1:0] m_shd [N_CH];
  logic [PW-1:0] m_act [N_CH];
  bit m_applied, m_pend, m_valid, m_resync, m_fs, m_err;
  int m_rs, m_slot, m_ch;
  logic [PW-1:0] m_phase;

  logic [71:0] got;
  assign got = {phase_valid, resync_out, ch_out, frame_start, commit_pending, cfg_err, phase_out};

  function automatic logic [71:0] expv();
    return {m_valid, m_resync, 3'(m_ch), m_fs, m_pend, m_err, m_phase};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin m_shd[i] = '0; m_act[i] = '0; end
    m_applied = 0; m_pend = 0; m_valid = 0; m_resync = 0; m_fs = 0; m_err = 0;
    m_rs = 0; m_slot = 0; m_ch = 0; m_phase = '0;
  endfunction

  // Apply one cycle of inputs, step the model, and stop 1 time unit past the edge.
  task automatic cyc(input bit wr, input int ch, input logic [31:0] pinc,
                     input logic [31:0] poff, input bit commit, input bit tick);
    bit emit, xfer;
    cfg_wr = wr; cfg_ch = 8'(ch); cfg_pinc = pinc; cfg_poff = poff;
    cfg_commit = commit; tick_in = tick;
    @(posedge clk);
    emit = tick && (m_applied || m_pend);
    xfer = emit && m_pend && (m_slot == 0);
    m_valid = emit;
    if (emit) begin
      m_ch = m_slot;
      m_phase = xfer ? m_shd[0] : m_act[m_slot];
      m_resync = xfer || (m_rs > 0);
      m_fs = (m_slot == 0);
    end
    if (xfer) begin
      for (int i = 0; i < N_CH; i++) m_act[i] = m_shd[i];
      m_applied = 1; m_rs = N_CH - 1;
    end else if (emit && m_rs > 0) m_rs--;
    if (emit) m_slot = (m_slot + 1) % N_CH;
    if (xfer) m_pend = 0;
    else if (commit) m_pend = 1;
    if (wr) begin
      if (ch < N_CH) m_shd[ch] = {poff, pinc};
      else m_err = 1;
    end
    #1;
    cfg_wr = 0; cfg_commit = 0; tick_in = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (got !== 72'd0) begin
      errs++; $display("FAIL reset_state got=%h exp=0", got);
    end
    resetn = 1;
    cyc(0, 0, 0, 0, 0, 1);   // tick in IDLE is ignored
    cyc(0, 0, 0, 0, 0, 1);
    vec++;
    if (got !== expv() || phase_valid !== 1'b0) begin
      errs++; $display("FAIL idle_tick got=%h exp=%h", got, expv());
    end
  endtask

  task automatic test_basic();
    cyc(1, 0, 32'h0001_0000, 32'h0, 0, 0);
    cyc(1, 3, 32'h0020_0000, 32'h8000_0000, 0, 0);
    for (int c = 1; c < N_CH; c++)
      if (c != 3) cyc(1, c, $urandom, $urandom, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 2 * N_CH; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      vec++;
      if (got !== expv()) begin
        errs++; $display("FAIL basic_slot k=%0d got=%h exp=%h", k, got, expv());
      end
      vec++;
      if (k == 3 && phase_out !== 64'h8000_0000_0020_0000) begin
        errs++; $display("FAIL basic_ch3 got=%h exp=8000000000200000", phase_out);
      end
    end
  endtask

  task automatic test_midframe();
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1);   // slots 0..4
    cyc(1, 0, 32'h1234, 32'h0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      vec++;
      if (got !== expv()) begin
        errs++; $display("FAIL midframe k=%0d got=%h exp=%h", k, got, expv());
      end
      vec++;
      if (k == 3 && ({phase_out, resync_out, commit_pending} !== {64'h1234, 1'b1, 1'b0})) begin
        errs++; $display("FAIL midframe_apply got=%h/%b/%b exp=1234/1/0", phase_out, resync_out, commit_pending);
      end
    end
  endtask

  task automatic test_gapped();
    for (int k = 0; k < 48; k++) begin
      cyc(0, 0, 0, 0, 0, (k % 4) == 0);
      vec++;
      if (got !== expv()) begin
        errs++; $display("FAIL gapped k=%0d got=%h exp=%h", k, got, expv());
      end
    end
  endtask

  task automatic test_bad_ch();
    cyc(1, 9, $urandom, $urandom, 0, 0);
    vec++;
    if (cfg_err !== 1'b1 || got !== expv()) begin
      errs++; $display("FAIL bad_ch got=%h exp=%h", got, expv());
    end
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 2 * N_CH + 2; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      vec++;
      if (got !== expv() || cfg_err !== 1'b1) begin
        errs++; $display("FAIL bad_ch_sticky k=%0d got=%h exp=%h", k, got, expv());
      end
    end
  endtask

  task automatic test_rsync_commit();
    bit seen = 0;
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3 * N_CH && !seen; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      seen = phase_valid && frame_start && resync_out;
    end
    vec++;
    if (!seen) begin
      errs++; $display("FAIL rsync_start got=0 exp=1");
    end
    cyc(0, 0, 0, 0, 0, 1);   // slot 1
    cyc(0, 0, 0, 0, 0, 1);   // slot 2
    cyc(1, 1, 32'h0000_ABCD, $urandom, 1, 0);
    for (int k = 0; k < 2 * N_CH; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      vec++;
      if (got !== expv()) begin
        errs++; $display("FAIL rsync_commit k=%0d got=%h exp=%h", k, got, expv());
      end
      vec++;
      if (k == 6 && (phase_out[31:0] !== 32'h0000_ABCD || resync_out !== 1'b1 || ch_out !== 3'd1)) begin
        errs++; $display("FAIL rsync_ch1 got=%h/%b/%0d exp=abcd/1/1", phase_out[31:0], resync_out, ch_out);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 4) == 0, $urandom_range(0, 9), $urandom, $urandom,
          ($urandom % 20) == 0, ($urandom % 3) != 0);
      vec++;
      if (got !== expv()) begin
        errs++; $display("FAIL random k=%0d got=%h exp=%h", k, got, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3 * N_CH && !seen; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      seen = phase_valid && frame_start && resync_out;
    end
    cyc(0, 0, 0, 0, 1, 1);   // latch a commit mid-RSYNC
    vec++;
    if (!seen || phase_valid !== 1'b1 || resync_out !== 1'b1 || commit_pending !== 1'b1) begin
      errs++; $display("FAIL reset_mid_pre got=%b%b%b exp=111", phase_valid, resync_out, commit_pending);
    end
    #2 resetn = 0;
    #1;
    model_reset();
    vec++;
    if ({phase_valid, resync_out, commit_pending} !== 3'b000 || got !== 72'd0) begin
      errs++; $display("FAIL reset_async got=%h exp=0", got);
    end
    @(negedge clk);
    resetn = 1;
    for (int k = 0; k < 2 * N_CH; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      vec++;
      if (got !== expv() || phase_valid !== 1'b0) begin
        errs++; $display("FAIL reset_recommit k=%0d got=%h exp=%h", k, got, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_gapped();
    test_bad_ch();
    test_rsync_commit();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/ddc_phase_sched.md
Name: ddc_phase_sched

Overview:
- Time-division phase scheduler for the DDC datapath. It holds per-channel DDS phase increment and offset words, written through a simple config port into shadow registers.
- On each sample tick it emits one channel's phase word, round-robin over N_CH channels, to the DDC phase/valid/resync inputs.
- Config changes apply atomically at a frame boundary. Channel 0 starts a frame. The first frame after a commit carries resync on every channel.

Parameters:
- N_CH, 8, number of time-multiplexed channels; power of 2, 2..64.
- PINC_W, 32, phase increment width.
- POFF_W, 32, phase offset width.
- CH_W, $clog2(N_CH), channel index width (derived).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cfg_wr  in  1  shadow write strobe
- cfg_ch  in  8  channel index for the write
- cfg_pinc  in  PINC_W  phase increment to store
- cfg_poff  in  POFF_W  phase offset to store
- cfg_commit  in  1  request shadow->active transfer with resync
- tick_in  in  1  sample strobe; one channel slot per tick
- phase_out  out  PINC_W+POFF_W  {poff, pinc} for the current slot
- phase_valid  out  1  phase_out valid (drives DDC valid_in)
- resync_out  out  1  resync flag for the current slot
- ch_out  out  CH_W  channel index of the current slot
- frame_start  out  1  high with slot ch 0
- commit_pending  out  1  commit accepted, not yet applied
- cfg_err  out  1  sticky; set on a write with cfg_ch >= N_CH

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; shadow and active registers 0.
  - slot counter 0; state IDLE; cfg_err cleared.
- Shadow write:
  - cfg_wr with cfg_ch < N_CH updates shadow[cfg_ch] on the next edge, in any state.
  - cfg_ch >= N_CH: no write; cfg_err set until reset.
- States:
  - IDLE: no config applied. Ticks are ignored, phase_valid stays 0, slot counter stays 0. cfg_commit -> PEND.
  - PEND: commit_pending = 1. The transfer happens on the first tick that would start slot 0. In IDLE that is the next tick; in RUN it is the tick after slot N_CH-1. On that edge, active <= shadow (all channels in one cycle) and state -> RSYNC.
  - RSYNC: one full frame of N_CH slots with resync_out = 1. After slot N_CH-1 -> RUN, or -> RSYNC again if a commit was latched during RSYNC.
  - RUN: normal streaming with resync_out = 0. cfg_commit -> PEND.
- Slot emission:
  - tick_in at edge t (state not IDLE) gives at t+1: phase_valid = 1, ch_out = slot, phase_out = active[slot] (values after any same-edge transfer), frame_start = (slot == 0).
  - Slot counter increments, wrapping N_CH-1 -> 0.
  - No tick: phase_valid = 0 the following cycle; other outputs hold.
  - Latency is 1 cycle, and ticks may arrive back-to-back every cycle.
- Commit and write interactions:
  - cfg_commit while already PEND: no effect, single transfer.
  - cfg_commit during RSYNC: latched; commit_pending = 1.
  - cfg_wr together with cfg_commit: the write is included in the transfer.
  - cfg_wr during PEND before the transfer edge: included.
  - cfg_wr on the transfer edge itself: lands in shadow only, not in active.
- Transfer-edge tick: a tick on the transfer edge emits slot 0 from the new active values with resync_out = 1.
- Reset mid-frame: outputs drop immediately, state returns to IDLE, and a re-commit is required.

Test Plan:
- Reset, then write ch0 pinc=0x00010000 poff=0, ch3 pinc=0x00200000 poff=0x80000000; commit; 8 consecutive ticks -> slots 0..7 with resync_out=1 and frame_start only on slot 0; slot 3 phase_out=0x80000000_00200000; the next 8 ticks have resync_out=0.
- Mid-frame commit in RUN at slot 4, after a new ch0 pinc=0x1234 write -> slots 5..7 keep the old values with commit_pending=1; the next slot 0 shows 0x1234 with resync=1, and commit_pending clears on that edge.
- Ticks gapped 1-in-4 -> phase_valid one cycle after each tick only; slot order unbroken 0..7 wrap 0.
- Write to cfg_ch=9 with N_CH=8 -> no register changes; cfg_err=1 persists through a later commit; cleared only by resetn.
- Commit during RSYNC at slot 2, with ch1 rewritten to 0xABCD -> a second RSYNC frame follows immediately; ch1 = 0xABCD in it.
- Assert resetn=0 mid-RSYNC -> phase_valid, resync_out and commit_pending go 0 without a clock edge; after release, ticks produce no valid output until a commit.
